// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encoding and the
// opcode classification helpers used by both the datapath and the
// carry-chain bookkeeping in the pipeline stage.
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_ADC = 4'd8,
    OP_SBC = 4'd9,
    OP_ASR = 4'd10
  } op_e;

  // Add/subtract family: the only ops that can raise signed overflow.
  function automatic logic is_arith(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Shift family: carry is the last bit pushed out of the operand.
  function automatic logic is_shift(input logic [OP_W-1:0] op);
    case (op)
      OP_SHL, OP_SHR, OP_ASR: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Ops whose carry output is written into the persistent carry flag.
  function automatic logic updates_carry(input logic [OP_W-1:0] op);
    return is_arith(op) | is_shift(op);
  endfunction

  // Ops that consume the stored carry flag as carry/borrow-in.
  function automatic logic uses_cin(input logic [OP_W-1:0] op);
    case (op)
      OP_ADC, OP_SBC: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  // Opcodes 11..15 are unassigned and flagged as errors.
  function automatic logic is_reserved(input logic [OP_W-1:0] op);
    return (op > OP_ASR);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath. Produces the WIDTH-bit result plus
// carry/borrow, signed overflow and the reserved-opcode error indication.
// zero/neg are derived from the result by the pipeline stage.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  logic [SHW-1:0] amt_s;
  logic           cin_eff_s;
  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;
  logic [WIDTH:0] shl_s;
  logic [WIDTH:0] shr_s;
  logic [WIDTH:0] asr_s;
  logic           add_ovf_s;
  logic           sub_ovf_s;

  assign amt_s     = b[SHW-1:0];
  // ADD/SUB ignore the stored carry; only ADC/SBC chain through it.
  assign cin_eff_s = uses_cin(op) ? cin : 1'b0;

  // One extra bit on every intermediate captures carry-out, borrow-out
  // or the last bit shifted out, so no separate carry logic is needed.
  assign sum_s  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_eff_s};
  assign diff_s = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin_eff_s};
  // Left shift: bit WIDTH holds the last bit out (0 when amount is 0).
  assign shl_s  = {1'b0, a} << amt_s;
  // Right shifts: a guard bit below the LSB catches the last bit out.
  assign shr_s  = {a, 1'b0} >> amt_s;
  assign asr_s  = $signed({a, 1'b0}) >>> amt_s;

  // Signed overflow: operands agree in sign (add) or differ (subtract)
  // and the result sign departs from operand A. Holds with carry-in too.
  assign add_ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1]  != a[WIDTH-1]);
  assign sub_ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);

  // Opcode decode selecting result and flags.
  always_comb begin
    result = {WIDTH{1'b0}};
    carry  = 1'b0;
    ovf    = 1'b0;
    err    = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        result = sum_s[WIDTH-1:0];
        carry  = sum_s[WIDTH];
        ovf    = add_ovf_s;
      end
      OP_SUB, OP_SBC: begin
        result = diff_s[WIDTH-1:0];
        carry  = diff_s[WIDTH];
        ovf    = sub_ovf_s;
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = shl_s[WIDTH-1:0];
        carry  = shl_s[WIDTH];
      end
      OP_SHR: begin
        result = shr_s[WIDTH:1];
        carry  = shr_s[0];
      end
      OP_ASR: begin
        result = asr_s[WIDTH:1];
        carry  = asr_s[0];
      end
      default: begin
        result = {WIDTH{1'b0}};
        err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU stage with valid/ready on both sides and a persistent
// carry flag for chaining WIDTH-bit slices into wider arithmetic.
// One op per cycle; results appear the cycle after acceptance and are
// held until the consumer takes them.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             err,
  output logic             cflag
);

  localparam int SHW = $clog2(WIDTH);

  logic             accept_s;
  logic             drain_s;
  logic             cin_s;
  logic [WIDTH-1:0] core_result_s;
  logic             core_carry_s;
  logic             core_ovf_s;
  logic             core_err_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_r;
  logic             zero_r;
  logic             neg_r;
  logic             ovf_r;
  logic             err_r;
  logic             cflag_r;

  // Ready depends only on the output register and the consumer, never on
  // in_valid, so upstream logic cannot form a combinational loop.
  assign in_ready = !out_valid_r || out_ready;
  assign accept_s = in_valid && in_ready;
  assign drain_s  = out_valid_r && out_ready;

  // A clear arriving with an op forces that op's carry-in to zero.
  assign cin_s = carry_clr ? 1'b0 : cflag_r;

  alu_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .a      (a),
    .b      (b),
    .op     (op),
    .cin    (cin_s),
    .result (core_result_s),
    .carry  (core_carry_s),
    .ovf    (core_ovf_s),
    .err    (core_err_s)
  );

  // Output register: load on accept, release on drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
      neg_r       <= 1'b0;
      ovf_r       <= 1'b0;
      err_r       <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      result_r    <= core_result_s;
      carry_r     <= core_carry_s;
      zero_r      <= (core_result_s == {WIDTH{1'b0}});
      neg_r       <= core_result_s[WIDTH-1];
      ovf_r       <= core_ovf_s;
      err_r       <= core_err_s;
    end else if (drain_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Carry chain state: an accepted carry-producing op wins over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cflag_r <= 1'b0;
    end else if (accept_s && updates_carry(op)) begin
      cflag_r <= core_carry_s;
    end else if (carry_clr) begin
      cflag_r <= 1'b0;
    end else begin
      cflag_r <= cflag_r;
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign carry     = carry_r;
  assign zero      = zero_r;
  assign neg       = neg_r;
  assign ovf       = ovf_r;
  assign err       = err_r;
  assign cflag     = cflag_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at WIDTH=4: directed cases followed by
// randomized traffic against an arithmetic reference model and queue.
module tb_alu_pipe;

  localparam int W  = 4;
  localparam int SH = 2;
  localparam int M  = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         neg;
  logic         ovf;
  logic         err;
  logic         cflag;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  typedef struct {
    int res;
    bit c;
    bit z;
    bit n;
    bit o;
    bit e;
    bit upd;
  } exp_t;

  exp_t q[$];
  bit   m_cflag = 1'b0;
  int   drained = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .carry_clr (carry_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf),
    .err       (err),
    .cflag     (cflag)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    assert_cnt++;
    if (obs !== exp_v) begin
      fail_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t ref_op(input int opc, input int av, input int bv, input int cin);
    exp_t r;
    int sa, sb, s, ss, sh, ci;
    r.res = 0; r.c = 0; r.z = 0; r.n = 0; r.o = 0; r.e = 0; r.upd = 0;
    sa = (av >= (1 << (W-1))) ? av - (1 << W) : av;
    sb = (bv >= (1 << (W-1))) ? bv - (1 << W) : bv;
    sh = bv % (1 << SH);
    ci = (opc == 8 || opc == 9) ? cin : 0;
    case (opc)
      0, 8: begin
        s = av + bv + ci;
        ss = sa + sb + ci;
        r.res = s % (M + 1);
        r.c = (s > M);
        r.o = (ss > M / 2) || (ss < -((M + 1) / 2));
        r.upd = 1'b1;
      end
      1, 9: begin
        s = av - bv - ci;
        ss = sa - sb - ci;
        r.res = (s + 2 * (M + 1)) % (M + 1);
        r.c = (s < 0);
        r.o = (ss > M / 2) || (ss < -((M + 1) / 2));
        r.upd = 1'b1;
      end
      2: r.res = av & bv;
      3: r.res = av | bv;
      4: r.res = av ^ bv;
      5: r.res = M - av;
      6: begin
        r.res = (av << sh) % (M + 1);
        r.c = (sh != 0) && ((((av << sh) >> W) & 1) != 0);
        r.upd = 1'b1;
      end
      7: begin
        r.res = av >> sh;
        r.c = (sh != 0) && (((av >> (sh - 1)) & 1) != 0);
        r.upd = 1'b1;
      end
      10: begin
        r.res = (sa >>> sh) & M;
        r.c = (sh != 0) && (((sa >>> (sh - 1)) & 1) != 0);
        r.upd = 1'b1;
      end
      default: r.e = 1'b1;
    endcase
    r.z = (r.res == 0);
    r.n = (((r.res >> (W - 1)) & 1) != 0);
    return r;
  endfunction

  // One clock: drive at negedge, check against model, advance model.
  task automatic do_cycle(input bit r, input bit iv, input int op_i, input int a_i, input int b_i,
                          input bit clr, input bit ordy, output bit acc);
    bit   exp_ready;
    bit   drn;
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = iv; op = op_i[3:0]; a = a_i[W-1:0]; b = b_i[W-1:0];
    carry_clr = clr; out_ready = ordy;
    #1;
    exp_ready = (q.size() == 0) || ordy;
    check_val("in_ready", in_ready, exp_ready);
    check_val("out_valid", out_valid, q.size() != 0);
    check_val("cflag", cflag, m_cflag);
    if (q.size() != 0) begin
      check_val("result", result, q[0].res);
      check_val("carry", carry, q[0].c);
      check_val("zero", zero, q[0].z);
      check_val("neg", neg, q[0].n);
      check_val("ovf", ovf, q[0].o);
      check_val("err", err, q[0].e);
    end
    acc = 1'b0;
    if (r) begin
      q.delete();
      m_cflag = 1'b0;
    end else begin
      drn = (q.size() != 0) && ordy;
      acc = iv && exp_ready;
      if (drn) begin
        void'(q.pop_front());
        drained++;
      end
      if (acc) begin
        e = ref_op(op_i, a_i, b_i, clr ? 0 : int'(m_cflag));
        q.push_back(e);
        if (e.upd) m_cflag = e.c;
        else if (clr) m_cflag = 1'b0;
      end else if (clr) begin
        m_cflag = 1'b0;
      end
    end
    @(posedge clk);
  endtask

  // Directed expectation on the output register just after an accept.
  task automatic expect_out(input string tag, input int res, input bit c, input bit z, input bit n,
                            input bit o, input bit e, input bit cf);
    #2;
    check_val({tag, "_ov"}, out_valid, 1);
    check_val({tag, "_res"}, result, res);
    check_val({tag, "_c"}, carry, c);
    check_val({tag, "_z"}, zero, z);
    check_val({tag, "_n"}, neg, n);
    check_val({tag, "_o"}, ovf, o);
    check_val({tag, "_e"}, err, e);
    check_val({tag, "_cf"}, cflag, cf);
  endtask

  initial begin
    bit acc;
    int idx;
    int d0;
    int bp_op[4] = '{0, 4, 1, 6};
    int bp_a[4]  = '{1, 5, 2, 3};
    int bp_b[4]  = '{2, 3, 7, 2};

    rst = 1'b1; in_valid = 1'b0; op = 4'd0; a = '0; b = '0;
    carry_clr = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_val("rst_ov", out_valid, 0);
    check_val("rst_res", result, 0);
    check_val("rst_flags", {carry, zero, neg, ovf, err}, 0);
    check_val("rst_cf", cflag, 0);
    check_val("rst_rdy", in_ready, 1);

    do_cycle(0, 1, 0, 5, 3, 0, 1, acc);   expect_out("add1", 8, 0, 0, 1, 1, 0, 0);
    do_cycle(0, 1, 0, 15, 15, 0, 1, acc); expect_out("add2", 14, 1, 0, 1, 0, 0, 1);
    do_cycle(0, 1, 8, 0, 0, 0, 1, acc);   expect_out("adc1", 1, 0, 0, 0, 0, 0, 0);
    do_cycle(0, 1, 1, 3, 5, 0, 1, acc);   expect_out("sub1", 14, 1, 0, 1, 0, 0, 1);
    do_cycle(0, 1, 9, 0, 0, 0, 1, acc);   expect_out("sbc1", 15, 1, 0, 1, 0, 0, 1);
    do_cycle(0, 1, 1, 15, 15, 0, 1, acc); expect_out("sub2", 0, 0, 1, 0, 0, 0, 0);
    do_cycle(0, 1, 6, 5, 1, 0, 1, acc);   expect_out("shl1", 10, 0, 0, 1, 0, 0, 0);
    do_cycle(0, 1, 10, 8, 2, 0, 1, acc);  expect_out("asr1", 14, 0, 0, 1, 0, 0, 0);
    do_cycle(0, 1, 7, 5, 1, 0, 1, acc);   expect_out("shr1", 2, 1, 0, 0, 0, 0, 1);
    do_cycle(0, 1, 12, 7, 3, 0, 1, acc);  expect_out("rsv", 0, 0, 1, 0, 0, 1, 1);
    do_cycle(0, 1, 0, 15, 1, 0, 1, acc);  expect_out("add3", 0, 1, 1, 0, 0, 0, 1);
    do_cycle(0, 1, 8, 1, 1, 1, 1, acc);   expect_out("adcclr", 2, 0, 0, 0, 0, 0, 0);

    // Back-pressure: consumer stalls three cycles, producer keeps offering.
    do_cycle(0, 0, 0, 0, 0, 0, 1, acc);
    d0 = drained;
    idx = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (idx < 4) do_cycle(0, 1, bp_op[idx], bp_a[idx], bp_b[idx], 0, cyc >= 3, acc);
      else         do_cycle(0, 0, 0, 0, 0, 0, cyc >= 3, acc);
      if (acc) idx++;
    end
    check_val("bp_acc", idx, 4);
    check_val("bp_drain", drained - d0, 4);

    // Reset while a result is held and carry flag is set.
    do_cycle(0, 1, 0, 15, 1, 0, 0, acc);
    do_cycle(1, 1, 8, 3, 3, 0, 0, acc);
    #2;
    check_val("mrst_ov", out_valid, 0);
    check_val("mrst_cf", cflag, 0);
    check_val("mrst_res", result, 0);
    check_val("mrst_rdy", in_ready, 1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      do_cycle(0, $urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, M),
               $urandom_range(0, M), $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, acc);
    end
    repeat (3) do_cycle(0, 0, 0, 0, 0, 0, 1, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered ALU with a valid/ready handshake on both sides and a persistent carry flag, so WIDTH-bit operands can be chained into wider arithmetic. It supersedes the 4-bit combinational ALU as the datapath execution unit. It accepts one operation per cycle and returns the result and flags one cycle later, honouring downstream back-pressure.

## Interface
- WIDTH, 8, operand/result width in bits (≥2).
- SHW, $clog2(WIDTH), shift-amount field width (derived; not overridden).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept this cycle.
- op  in  4  opcode (Operation).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; for shifts, b[SHW-1:0] is the amount.
- carry_clr  in  1  clear stored carry flag.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  result.
- carry, zero, neg, ovf, err  out  1 each  flags for result.
- cflag  out  1  stored carry flag (chain state).

## Operation
- Opcodes: 0 ADD a+b; 1 SUB a−b; 2 AND; 3 OR; 4 XOR; 5 NOT ~a; 6 SHL a<<n; 7 SHR a>>n (logical); 8 ADC a+b+cflag; 9 SBC a−b−cflag; 10 ASR a>>>n; 11–15 reserved.
- n = b[SHW-1:0]; n ≥ WIDTH (non-power-of-two WIDTH) yields result 0 (ASR: all sign bits).
- carry: ADD/ADC carry-out; SUB/SBC borrow-out (1 when the unsigned true difference < 0); shifts: last bit shifted out, 0 when n=0; logic ops/NOT: 0.
- zero = (result==0); neg = result[WIDTH-1]; ovf = signed overflow for ADD/SUB/ADC/SBC, else 0.
- Reserved op: result 0, carry 0, zero 1, neg 0, ovf 0, err 1; cflag unchanged. err=0 for valid ops.
- cflag: updated on accept by ADD/SUB/ADC/SBC/SHL/SHR/ASR with that op's carry; unchanged by logic ops, NOT, reserved.
- carry_clr: clears cflag at the edge. If it coincides with an accepted op, that op uses carry-in 0 and its own carry update wins (cflag = op carry if op updates it, else 0).

## Timing
- Accept when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational; no in_valid→in_ready path).
- Latency 1: result/flags computed in the accept cycle, registered; out_valid high the next cycle.
- Result held stable with out_valid until out_valid && out_ready. Simultaneous drain and accept gives back-to-back throughput of 1 op/cycle.
- Back-to-back ADC/SBC see the cflag of the immediately preceding accepted op; there is no hazard.
- Reset values: out_valid 0, result 0, carry/zero/neg/ovf/err 0, cflag 0; in_ready reads 1 after reset.
- Reset mid-operation: any held result is discarded and the handshake inputs are ignored in the reset cycle.

## Structure
- Package alu_pkg: opcode localparams/enum (OP_ADD…OP_ASR) and the is_arith / updates_carry helper functions.
- Sub-module alu_core: purely combinational (a, b, op, cin) → (result, carry, ovf, err). alu_pipe holds the output register, handshake and cflag.

## Test plan
- WIDTH=4, ADD 0101+0011 → result 1000, carry 0, ovf 1, neg 1, zero 0, out_valid one cycle after accept.
- ADD 1111+1111 → 1110, carry 1, cflag 1; next ADC 0000+0000 → 0001, carry 0, cflag 0.
- SUB 0011−0101 → 1110, carry 1; next SBC 0000−0000 → 1111, carry 1; SUB 1111−1111 → 0000, zero 1, carry 0.
- SHL 0101 n=1 → 1010, carry 0; SHR 0101 n=1 → 0010, carry 1; ASR 1000 n=2 → 1110; op 12 → 0000, err 1, cflag unchanged.
- Hold out_ready=0 for 3 cycles with in_valid=1: in_ready 0, result stable, no op lost; release → streaming at 1/cycle, order preserved.
- Set cflag=1 via ADD 1111+0001, then carry_clr with ADC 0001+0001 → 0010, cflag 0. Assert rst with out_valid=1 → out_valid 0 and cflag 0 next cycle.
